// File: rtl/ecc_sed_pkg.sv
// Shared SED codeword definitions: 12 data bits plus one even-parity bit at the MSB.
// The encoder and decoder both use parity() so the two ends agree on the rule.
package ecc_sed_pkg;

  localparam int DATA_W  = 12;
  localparam int CW_W    = DATA_W + 1;
  localparam int PAR_IDX = DATA_W;

  // Callers zero-extend into 64 bits; the extra zeros leave the XOR unchanged.
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ecc_sed_err_stat.sv
// Sticky error flag plus saturating error counter for ECC checker status.
// When an error and a clear arrive together, the new error wins and is counted.
module ecc_sed_err_stat #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err_evt,
  input  logic             clr_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_evt) begin
      err_sticky <= 1'b1;
      if (clr_err)
        err_count <= CNT_W'(1);
      else if (!(&err_count))
        err_count <= err_count + 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end
  end

endmodule

// File: rtl/ecc_sed_decoder.sv
// Receive-side SED checker: registers each valid codeword, strips the parity bit
// and flags a parity mismatch, with sticky/counted error status.
module ecc_sed_decoder #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_valid,
  input  logic [DATA_W:0]   enc_codeword,
  input  logic              clr_err,
  output logic              data_valid,
  output logic [DATA_W-1:0] data,
  output logic              err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count
);

  import ecc_sed_pkg::*;

  logic syndrome;
  logic err_evt;

  assign syndrome = parity(64'(enc_codeword));
  // Bad parity on an invalid cycle is not an event.
  assign err_evt  = enc_valid & syndrome;

  // Data is forwarded even on error; the consumer decides whether to drop it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      data       <= '0;
      err        <= 1'b0;
    end else begin
      data_valid <= enc_valid;
      err        <= err_evt;
      if (enc_valid)
        data <= enc_codeword[DATA_W-1:0];
    end
  end

  ecc_sed_err_stat #(
    .CNT_W (CNT_W)
  ) u_err_stat (
    .clk        (clk),
    .rst        (rst),
    .err_evt    (err_evt),
    .clr_err    (clr_err),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Self-checking bench for ecc_sed_decoder using a small counter width so saturation
// is reached quickly; a behavioural model tracks the expected outputs.
module tb_ecc_sed_decoder;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SW = 1 + DATA_W + 1 + 1 + CNT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              enc_valid;
  logic [DATA_W:0]   enc_codeword;
  logic              clr_err;
  logic              data_valid;
  logic [DATA_W-1:0] data;
  logic              err;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit  m_vld, m_err, m_sticky;
  int  m_data, m_cnt;

  ecc_sed_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_valid    (enc_valid),
    .enc_codeword (enc_codeword),
    .clr_err      (clr_err),
    .data_valid   (data_valid),
    .data         (data),
    .err          (err),
    .err_sticky   (err_sticky),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] dut_vec();
    return {data_valid, data, err, err_sticky, err_count};
  endfunction

  function automatic logic [SW-1:0] model_vec();
    return {m_vld, DATA_W'(m_data), m_err, m_sticky, CNT_W'(m_cnt)};
  endfunction

  // Drive one cycle, wait past the edge, and advance the model by the rules.
  task automatic cycle(input bit r, input bit v, input logic [DATA_W:0] cw, input bit clr);
    bit bad;
    rst = r; enc_valid = v; enc_codeword = cw; clr_err = clr;
    @(posedge clk); #1;
    bad = ($countones(cw) % 2) == 1;
    if (r) begin
      m_vld = 0; m_data = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      m_vld = v;
      if (v) m_data = int'(cw) % (1 << DATA_W);
      m_err = v && bad;
      if (m_err) begin
        m_sticky = 1;
        m_cnt = clr ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
      end else if (clr) begin
        m_sticky = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 13'h1FFF, 0);
      checks++;
      if (dut_vec() !== '0) begin
        errors++; $display("FAIL reset[%0d] got %h exp 0", i, dut_vec());
      end
    end
    cycle(0, 1, 13'h1001, 0);
    checks++;
    if (dut_vec() !== {1'b1, 12'h001, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset_release got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_clean();
    logic [DATA_W:0] cws [2];
    logic [DATA_W-1:0] exp_d [2];
    cws[0] = 13'h0000; cws[1] = 13'h1001;
    exp_d[0] = 12'h000; exp_d[1] = 12'h001;
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, cws[i], 0);
      checks++;
      if (dut_vec() !== {1'b1, exp_d[i], 1'b0, 1'b0, 2'd0}) begin
        errors++; $display("FAIL clean[%0d] got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_single_err();
    cycle(0, 1, 13'h0001, 0);
    checks++;
    if (dut_vec() !== {1'b1, 12'h001, 1'b1, 1'b1, 2'd1}) begin
      errors++; $display("FAIL single_err got %h exp %h", dut_vec(), model_vec());
    end
    cycle(0, 0, 13'h0AAA, 0);
    checks++;
    if (dut_vec() !== {1'b0, 12'h001, 1'b0, 1'b1, 2'd1}) begin
      errors++; $display("FAIL single_err_idle got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_even_miss();
    cycle(0, 1, 13'h0003, 0);
    checks++;
    if (dut_vec() !== {1'b1, 12'h003, 1'b0, 1'b1, 2'd1}) begin
      errors++; $display("FAIL even_miss got %h exp %h", dut_vec(), model_vec());
    end
    cycle(0, 0, 13'h0001, 0);
    checks++;
    if (dut_vec() !== {1'b0, 12'h003, 1'b0, 1'b1, 2'd1}) begin
      errors++; $display("FAIL invalid_ignored got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_saturation();
    int seq [5] = '{1, 2, 3, 3, 3};
    cycle(0, 0, 13'h0000, 1);
    checks++;
    if (dut_vec() !== {1'b0, 12'h003, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL sat_clear got %h exp %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 13'h0001, 0);
      checks++;
      if (dut_vec() !== {1'b1, 12'h001, 1'b1, 1'b1, CNT_W'(seq[i])}) begin
        errors++; $display("FAIL saturation[%0d] got %h exp count %0d", i, dut_vec(), seq[i]);
      end
    end
  endtask

  task automatic test_clear_collision();
    cycle(0, 0, 13'h0000, 1);
    checks++;
    if (dut_vec() !== {1'b0, 12'h001, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL clear_alone got %h exp %h", dut_vec(), model_vec());
    end
    cycle(0, 1, 13'h1001, 0);
    cycle(0, 1, 13'h0001, 0);
    cycle(0, 1, 13'h0001, 0);
    cycle(0, 1, 13'h1000, 1);
    checks++;
    if (dut_vec() !== {1'b1, 12'h000, 1'b1, 1'b1, 2'd1}) begin
      errors++; $display("FAIL clear_collision got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_midstream_reset();
    cycle(0, 1, 13'h0ABC, 0);
    cycle(1, 1, 13'h0123, 0);
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL mid_reset got %h exp 0", dut_vec());
    end
    cycle(0, 1, 13'h1456, 0);
    checks++;
    if (dut_vec() !== model_vec() || data_valid !== 1'b1 || data !== 12'h456) begin
      errors++; $display("FAIL mid_reset_resume got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, v, clr;
      logic [DATA_W:0] cw;
      r   = ($urandom_range(0, 99) < 3);
      v   = ($urandom_range(0, 99) < 70);
      clr = ($urandom_range(0, 99) < 10);
      cw  = (DATA_W+1)'($urandom);
      cycle(r, v, cw, clr);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random[%0d] got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; enc_valid = 1'b0; enc_codeword = '0; clr_err = 1'b0;
    m_vld = 0; m_data = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    #1;
    test_reset();
    test_clean();
    test_single_err();
    test_even_miss();
    test_saturation();
    test_clear_collision();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
